// File: rtl/csa_resolve.sv
`default_nettype none
// ============================================================================
// Module   : csa_resolve
// Brief    : Resolves a 51-bit carry-save pair into a binary result, one
//            17-bit ripple chunk per cycle. CSA_RESOLVE_STICKY_EN enables the
//            registered sticky OR over the low STICKY_BITS result bits.
// Revision : 1.0 - initial release
// ============================================================================
module csa_resolve #(
    parameter int STICKY_BITS = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [50:0] sum,
    input  logic [50:0] carry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [50:0] result,
    output logic        cout,
    output logic        sticky
);

    localparam int c_CHUNK_W = 17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic   [1:0]           r_cnt;
    logic                   r_cc;
    logic   [50:0]          r_sum;
    logic   [50:0]          r_carry;
    logic   [50:0]          r_result;
    logic                   r_cout;

    logic   [c_CHUNK_W-1:0] w_a;
    logic   [c_CHUNK_W-1:0] w_b;
    logic   [c_CHUNK_W:0]   w_chunk;

    // Chunk k operands are selected from the captured pair by the counter.
    always_comb begin
        w_a = r_sum[16:0];
        w_b = r_carry[16:0];
        case (r_cnt)
            2'd0: begin
                w_a = r_sum[16:0];
                w_b = r_carry[16:0];
            end
            2'd1: begin
                w_a = r_sum[33:17];
                w_b = r_carry[33:17];
            end
            default: begin
                w_a = r_sum[50:34];
                w_b = r_carry[50:34];
            end
        endcase
        w_chunk = {1'b0, w_a} + {1'b0, w_b} + {{c_CHUNK_W{1'b0}}, r_cc};
    end

`ifdef CSA_RESOLVE_STICKY_EN
    localparam logic [50:0] c_STICKY_MASK = (51'd1 << STICKY_BITS) - 51'd1;

    logic        r_sticky;
    logic [50:0] w_final;

    // Full result as it will look after the last chunk is written.
    assign w_final = {w_chunk[16:0], r_result[33:0]};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 2'd0;
            r_cc     <= 1'b0;
            r_sum    <= '0;
            r_carry  <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
`ifdef CSA_RESOLVE_STICKY_EN
            r_sticky <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sum   <= sum;
                        r_carry <= carry;
                        r_cc    <= 1'b0;
                        r_cnt   <= 2'd0;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_cc <= w_chunk[c_CHUNK_W];
                    case (r_cnt)
                        2'd0: begin
                            r_result[16:0] <= w_chunk[16:0];
                            r_cnt          <= 2'd1;
                        end
                        2'd1: begin
                            r_result[33:17] <= w_chunk[16:0];
                            r_cnt           <= 2'd2;
                        end
                        default: begin
                            r_result[50:34] <= w_chunk[16:0];
                            r_cout          <= w_chunk[c_CHUNK_W];
                            r_cnt           <= 2'd0;
                            r_state         <= S_DONE;
`ifdef CSA_RESOLVE_STICKY_EN
                            r_sticky        <= |(w_final & c_STICKY_MASK);
`endif
                        end
                    endcase
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign cout      = r_cout;

`ifdef CSA_RESOLVE_STICKY_EN
    assign sticky = r_sticky;
`else
    assign sticky = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csa_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_resolve
// Brief    : Self-checking bench for csa_resolve against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_resolve;

    localparam int STICKY_BITS = 24;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [50:0] sum;
    logic [50:0] carry;
    logic        out_valid;
    logic        out_ready;
    logic [50:0] result;
    logic        cout;
    logic        sticky;

    int vectors = 0;
    int errors  = 0;

    csa_resolve #(.STICKY_BITS(STICKY_BITS)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum      (sum),
        .carry    (carry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .cout     (cout),
        .sticky   (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [50:0] rnd51();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return 51'h7FFFFFFFFFFFF;
            1:       return v[50:0] | 51'h1FFFF;
            default: return v[50:0];
        endcase
    endfunction

    // Reference: plain 52-bit addition; sticky derived from the low result bits.
    function automatic logic [51:0] model_sum(input logic [50:0] s, input logic [50:0] c);
        return {1'b0, s} + {1'b0, c};
    endfunction

    function automatic logic model_sticky(input logic [50:0] r);
`ifdef CSA_RESOLVE_STICKY_EN
        logic [63:0] m;
        m = (64'd1 << STICKY_BITS) - 64'd1;
        return (({13'd0, r} & m) != 64'd0);
`else
        return (r != r);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Accept one pair, check latency, hold in DONE for 'hold' cycles with a
    // competing pair offered, then release.
    task automatic run_pair(input logic [50:0] s, input logic [50:0] c, input int hold);
        logic [51:0] exp;
        exp = model_sum(s, c);
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        sum      = s;
        carry    = c;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        sum      = rnd51();
        carry    = rnd51();
        for (int i = 0; i < 2; i++) begin
            check("add_out_valid", {63'd0, out_valid}, 64'd0);
            step();
        end
        check("add_last_out_valid", {63'd0, out_valid}, 64'd0);
        step();
        check("done_out_valid", {63'd0, out_valid}, 64'd1);
        check("result", {13'd0, result}, {13'd0, exp[50:0]});
        check("cout", {63'd0, cout}, {63'd0, exp[51]});
        check("sticky", {63'd0, sticky}, {63'd0, model_sticky(exp[50:0])});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            sum      = rnd51();
            carry    = rnd51();
            step();
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_result", {13'd0, result}, {13'd0, exp[50:0]});
            check("hold_cout", {63'd0, cout}, {63'd0, exp[51]});
            check("hold_sticky", {63'd0, sticky}, {63'd0, model_sticky(exp[50:0])});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("release_out_valid", {63'd0, out_valid}, 64'd0);
        check("release_in_ready", {63'd0, in_ready}, 64'd1);
        check("idle_result_kept", {13'd0, result}, {13'd0, exp[50:0]});
        check("idle_cout_kept", {63'd0, cout}, {63'd0, exp[51]});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum       = '0;
        carry     = '0;
        @(negedge clk);
        step();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", {13'd0, result}, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        check("rst_sticky", {63'd0, sticky}, 64'd0);
        rst_n = 1'b1;
        step();

        run_pair(51'h1, 51'h2, 0);
        run_pair(51'h1FFFF, 51'h1, 1);
        run_pair(51'h7FFFFFFFFFFFF, 51'h2, 0);
        run_pair(51'h1234_5678_9ABC, 51'h0F0F_0F0F_0F0F, 5);
        run_pair(51'h1000000, 51'h0, 0);
        run_pair(51'h800000, 51'h0, 0);
        run_pair(51'h3FFFFFFFF, 51'h1, 2);

        // Reset in the middle of ADD (counter 1) discards the work.
        in_valid = 1'b1;
        sum      = 51'h7FFFFFFFFFFFF;
        carry    = 51'h7FFFFFFFFFFFF;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_result", {13'd0, result}, 64'd0);
        check("midrst_cout", {63'd0, cout}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("midrst_no_valid", {63'd0, out_valid}, 64'd0);
        end

        for (int n = 0; n < 40; n++) begin
            run_pair(rnd51(), rnd51(), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/csa_resolve.md
CSA_RESOLVE -- requirements
Module: csa_resolve

Interface
REQ-001 Parameter STICKY_BITS, default 24: number of low result bits OR-reduced into sticky (1..50).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream carry-save pair present.
REQ-005 in_ready  output  1  block can accept a pair this cycle.
REQ-006 sum  input  51  sum vector from the 3:2 compressor stage.
REQ-007 carry  input  51  carry vector from the 3:2 compressor stage, already shifted; bit 0 not assumed zero.
REQ-008 out_valid  output  1  result holds a resolved value.
REQ-009 out_ready  input  1  downstream consumes result this cycle.
REQ-010 result  output  51  (sum + carry) mod 2^51.
REQ-011 cout  output  1  carry out of bit 50.
REQ-012 sticky  output  1  OR of result[STICKY_BITS-1:0] (see Configuration).

Function
REQ-013 Block SHALL resolve carry-save pair with three 17-bit ripple chunks, one chunk per cycle, using a registered inter-chunk carry.
REQ-014 FSM states SHALL be IDLE, ADD, DONE; chunk counter SHALL be 2 bits, values 0..2.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: in_valid=1 SHALL capture sum and carry into internal registers, clear chunk carry, set counter 0, go to ADD.
REQ-017 ADD: each cycle SHALL write result[17k+16:17k] = captured chunk k sum + chunk k carry + chunk carry-in, update chunk carry, increment counter.
REQ-018 ADD with counter 2 SHALL write chunk 2, load cout with final chunk carry, and go to DONE.
REQ-019 Latency SHALL be 3 cycles: pair accepted at edge N gives out_valid=1 after edge N+3.
REQ-020 out_valid SHALL be 1 only in DONE.
REQ-021 DONE with out_ready=1 SHALL go to IDLE; out_valid SHALL drop after that edge.
REQ-022 DONE with out_ready=0 SHALL hold result, cout, sticky stable; in_valid SHALL be ignored.
REQ-023 Inputs sum and carry SHALL be don't-care after acceptance edge.
REQ-024 sticky SHALL be registered, computed from the final result, and valid with out_valid.
REQ-025 result and cout SHALL retain the last value in IDLE until overwritten by the next ADD.

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE, counter 0, chunk carry 0, result 0, cout 0, sticky 0, out_valid 0, in_ready 1 after that edge.
REQ-027 Reset in ADD or DONE SHALL discard the partial/held result; no out_valid pulse SHALL follow.

Configuration
REQ-028 Macro CSA_RESOLVE_STICKY_EN defined: sticky SHALL follow REQ-012/REQ-024.
REQ-029 Macro CSA_RESOLVE_STICKY_EN undefined: sticky port SHALL remain and be tied to constant 0; no OR-reduction logic.

Verification
REQ-030 sum=0x1, carry=0x2, accept at edge 0 -> out_valid after edge 3, result=0x3, cout=0.
REQ-031 sum=0x1FFFF, carry=0x1 -> result=0x20000, cout=0 (carry across chunk 0/1).
REQ-032 sum=0x7FFFFFFFFFFFF, carry=0x2 -> result=0x1, cout=1 (carry through all chunks).
REQ-033 out_ready=0 for 5 cycles in DONE, in_valid=1 with new data -> result/cout stable, in_ready=0, new pair not taken; out_ready=1 -> IDLE, then new pair accepted.
REQ-034 rst_n=0 during ADD counter 1 -> next cycle out_valid=0, in_ready=1, result=0, cout=0; no later out_valid without new accept.
REQ-035 Macro defined, STICKY_BITS=24: result 0x1000000 -> sticky=0; result 0x800000 -> sticky=1; macro undefined -> sticky=0 for both.
